fetch_redirect_arbiter: RTL

FETCH_REDIRECT_ARBITER -- requirements
Module: fetch_redirect_arbiter

---
 rtl/fetch_redirect_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/fetch_redirect_arbiter.sv
// Fetch redirect arbiter: picks excp > bru > if3 redirects, holds one pending target for the PC generator.
// Optional per-source capture statistics when REDIRECT_STATS_EN is defined.
module fetch_redirect_arbiter #(
  parameter int unsigned QUIET_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        excp_valid,
  input  logic [31:0] excp_pc,
  input  logic        bru_valid,
  input  logic [31:0] bru_pc,
  input  logic        if3_valid,
  input  logic [31:0] if3_pc,
  input  logic        pc_ready,
  output logic        redir_valid,
  output logic [31:0] redir_pc,
  output logic [1:0]  redir_src,
  output logic        flush_if,
  output logic        flush_be,
  output logic        busy
`ifdef REDIRECT_STATS_EN
  ,
  output logic [31:0] stat_excp_cnt,
  output logic [31:0] stat_bru_cnt,
  output logic [31:0] stat_if3_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_QUIET} state_t;

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_IF3  = 2'd1;
  localparam logic [1:0] SRC_BRU  = 2'd2;
  localparam logic [1:0] SRC_EXCP = 2'd3;
  localparam logic [2:0] QCNT     = 3'(QUIET_CYC);

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_cnt, w_cnt_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [1:0]  r_src, w_src_nxt;
  logic        r_flush_if, w_flush_if_nxt;
  logic        r_flush_be, w_flush_be_nxt;
  logic        w_capture;
  logic        w_if3_ok;
  logic [1:0]  w_req_src;
  logic [31:0] w_req_pc;

  // IF3 predecode redirects are stale right after a redirect, so QUIET masks them.
  assign w_if3_ok = if3_valid && (r_state != S_QUIET);

  always_comb begin
    w_req_src = SRC_NONE;
    w_req_pc  = 32'd0;
    if (excp_valid) begin
      w_req_src = SRC_EXCP;
      w_req_pc  = excp_pc;
    end else if (bru_valid) begin
      w_req_src = SRC_BRU;
      w_req_pc  = bru_pc;
    end else if (w_if3_ok) begin
      w_req_src = SRC_IF3;
      w_req_pc  = if3_pc;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_pc_nxt       = r_pc;
    w_src_nxt      = r_src;
    w_flush_if_nxt = 1'b0;
    w_flush_be_nxt = 1'b0;
    w_capture      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req_src != SRC_NONE) w_capture = 1'b1;
      end
      S_PEND: begin
        // A strictly higher-priority request wins even if the handshake fires this cycle.
        if (w_req_src > r_src) begin
          w_capture = 1'b1;
        end else if (pc_ready) begin
          w_pc_nxt  = 32'd0;
          w_src_nxt = SRC_NONE;
          if (QUIET_CYC == 0) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 3'd0;
          end else begin
            w_state_nxt = S_QUIET;
            w_cnt_nxt   = QCNT;
          end
        end
      end
      S_QUIET: begin
        if (w_req_src != SRC_NONE) begin
          w_capture = 1'b1;
        end else if (r_cnt <= 3'd1) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 3'd0;
        end else begin
          w_cnt_nxt = r_cnt - 3'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 3'd0;
        w_pc_nxt    = 32'd0;
        w_src_nxt   = SRC_NONE;
      end
    endcase
    if (w_capture) begin
      w_state_nxt    = S_PEND;
      w_cnt_nxt      = 3'd0;
      w_pc_nxt       = w_req_pc;
      w_src_nxt      = w_req_src;
      w_flush_if_nxt = 1'b1;
      w_flush_be_nxt = (w_req_src == SRC_EXCP);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 3'd0;
      r_pc       <= 32'd0;
      r_src      <= SRC_NONE;
      r_flush_if <= 1'b0;
      r_flush_be <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_pc       <= w_pc_nxt;
      r_src      <= w_src_nxt;
      r_flush_if <= w_flush_if_nxt;
      r_flush_be <= w_flush_be_nxt;
    end
  end

  assign redir_valid = (r_state == S_PEND);
  assign redir_pc    = r_pc;
  assign redir_src   = r_src;
  assign flush_if    = r_flush_if;
  assign flush_be    = r_flush_be;
  assign busy        = (r_state != S_IDLE);

`ifdef REDIRECT_STATS_EN
  logic [31:0] r_stat_excp, r_stat_bru, r_stat_if3;

  // Saturating; replacements count as captures of the new source.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_excp <= 32'd0;
      r_stat_bru  <= 32'd0;
      r_stat_if3  <= 32'd0;
    end else if (w_capture) begin
      case (w_req_src)
        SRC_EXCP: if (r_stat_excp != 32'hFFFF_FFFF) r_stat_excp <= r_stat_excp + 32'd1;
        SRC_BRU:  if (r_stat_bru  != 32'hFFFF_FFFF) r_stat_bru  <= r_stat_bru  + 32'd1;
        SRC_IF3:  if (r_stat_if3  != 32'hFFFF_FFFF) r_stat_if3  <= r_stat_if3  + 32'd1;
        default: ;
      endcase
    end
  end

  assign stat_excp_cnt = r_stat_excp;
  assign stat_bru_cnt  = r_stat_bru;
  assign stat_if3_cnt  = r_stat_if3;
`endif

endmodule
